// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - sequential instruction fetch unit feeding a circular fetch queue
//
// Purpose:
//   Fetches one 32-bit word per cycle from a combinational instruction memory
//   at the internal pc and pushes {pc, instr} into a QUEUE_DEPTH-entry
//   circular buffer. Downstream pops the head with a valid/ready handshake.
//   A redirect flushes the queue and restarts fetch at a word-aligned target.
//   Fetch stops (out_of_range) once the word at pc would not fit in memory.
//
// Parameters:
//   RESET_PC    - first fetch address after reset
//   QUEUE_DEPTH - fetch-queue entries, power of two, 2..16
//   MEM_SIZE    - instruction memory size in bytes, power of two
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-high reset
//   imem_addr      out  byte address to instruction memory (registered pc)
//   imem_instr     in   instruction at imem_addr, same cycle
//   redirect_valid in   flush queue and restart fetch at redirect_pc
//   redirect_pc    in   new fetch address (low two bits ignored)
//   deq_ready      in   downstream accepts queue head this cycle
//   deq_valid      out  queue head valid
//   deq_instr      out  queue-head instruction (0 when empty)
//   deq_pc         out  queue-head address (0 when empty)
//   out_of_range   out  fetch stopped, pc beyond memory
//
// Build option:
//   FETCH_TRACE_EN - enables simulation trace prints and sanity assertions;
//                    cycle behaviour is unchanged.

module instr_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4,
  parameter int          MEM_SIZE    = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        deq_ready,
  output logic        deq_valid,
  output logic [31:0] deq_instr,
  output logic [31:0] deq_pc,
  output logic        out_of_range
);

  localparam int          PTR_W     = $clog2(QUEUE_DEPTH);
  localparam int          CNT_W     = PTR_W + 1;
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_SIZE);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);

  typedef enum logic {
    ST_FETCH   = 1'b0,
    ST_STOPPED = 1'b1
  } state_e;

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      entry_q [QUEUE_DEPTH];

  state_e state;
  logic   full;
  logic   deq_fire;
  logic   enq_fire;

  // The two low redirect bits are dropped when aligning the target.
  logic [1:0] redirect_lsb_unused;
  assign redirect_lsb_unused = redirect_pc[1:0];

  // The fetch state is a pure function of pc: the widened add keeps pc+3
  // from wrapping near 2^32, so a wrapped pc always lands in STOPPED.
  always_comb begin
    state = (({1'b0, pc_q} + 33'd3) >= MEM_LIMIT) ? ST_STOPPED : ST_FETCH;
  end

  assign full     = (count_q == FULL_COUNT);
  assign deq_fire = deq_valid & deq_ready;
  // A full queue may still accept when its head leaves in the same cycle.
  assign enq_fire = (state == ST_FETCH) && !redirect_valid && (!full || deq_fire);

  // State register: pc, pointers and occupancy; reset empties the queue
  // immediately because deq_* are gated on the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage needs no reset: stale entries are never visible.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      entry_q[wr_ptr_q] <= {pc_q, imem_instr};
    end
  end

  // Next-state logic; redirect overrides any enqueue/dequeue this cycle.
  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (deq_fire) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Outputs
  always_comb begin
    imem_addr    = pc_q;
    out_of_range = (state == ST_STOPPED);
    deq_valid    = (count_q != '0);
    deq_pc       = 32'h0;
    deq_instr    = 32'h0;
    if (deq_valid) begin
      deq_pc    = entry_q[rd_ptr_q][63:32];
      deq_instr = entry_q[rd_ptr_q][31:0];
    end
  end

`ifdef FETCH_TRACE_EN
  always @(posedge clk) begin
    if (!reset) begin
      if (redirect_valid) begin
        $display("%0t instr_fetch: redirect to %h", $time, redirect_pc);
        assert (redirect_pc[1:0] == 2'b00)
          else $error("instr_fetch: misaligned redirect_pc %h", redirect_pc);
      end else if (enq_fire) begin
        $display("%0t instr_fetch: enqueue pc=%h instr=%h", $time, pc_q, imem_instr);
      end
      assert (!(enq_fire && full && !deq_fire))
        else $error("instr_fetch: enqueue into full queue without dequeue");
    end
  end
`else
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - table-driven self-checking bench for instr_fetch

module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_instr;
  logic [31:0] deq_pc;
  logic        out_of_range;

  // Memory model: word = address XOR key (key 0 gives word == address).
  logic [31:0] instr_key;
  assign imem_instr = imem_addr ^ instr_key;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC   (32'h0000_0000),
    .QUEUE_DEPTH(4),
    .MEM_SIZE   (1024)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .deq_ready     (deq_ready),
    .deq_valid     (deq_valid),
    .deq_instr     (deq_instr),
    .deq_pc        (deq_pc),
    .out_of_range  (out_of_range)
  );

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        eoor;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic rv, input logic [31:0] rpc,
                     input logic rdy, input logic ev, input logic [31:0] epc,
                     input logic [31:0] eaddr, input logic eoor);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.eoor = eoor;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [31:0] epc,
                         input logic [31:0] einstr, input logic [31:0] eaddr,
                         input logic eoor);
    chk({tag, " deq_valid"},    {31'b0, deq_valid},    {31'b0, ev});
    chk({tag, " deq_pc"},       deq_pc,                epc);
    chk({tag, " deq_instr"},    deq_instr,             einstr);
    chk({tag, " imem_addr"},    imem_addr,             eaddr);
    chk({tag, " out_of_range"}, {31'b0, out_of_range}, {31'b0, eoor});
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    deq_ready      = 1'b0;
    instr_key      = 32'h0;

    // Phase A: streaming with deq_ready=1, one pc per cycle.
    for (int k = 1; k <= 4; k++) add(0, 0, 0, 1, 1, 32'(4*(k-1)), 32'(4*k), 0);
    // Phase B: back-pressure for 10 cycles, then 8 full-throughput cycles.
    add(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++)  add(0, 0, 0, 0, 1, 0, 32'(4*k), 0);
    for (int k = 5; k <= 10; k++) add(0, 0, 0, 0, 1, 0, 32'd16, 0);
    for (int k = 11; k <= 18; k++) add(0, 0, 0, 1, 1, 32'(4*(k-10)), 32'(4*(k-10)+16), 0);
    // Phase C: redirect flushes a partially filled queue.
    add(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) add(0, 0, 0, 0, 1, 0, 32'(4*k), 0);
    add(0, 1, 32'h103, 0, 0, 0, 32'h100, 0);
    add(0, 0, 0,       1, 1, 32'h100, 32'h104, 0);
    add(0, 1, 32'h200, 1, 0, 0, 32'h200, 0);
    add(0, 0, 0,       1, 1, 32'h200, 32'h204, 0);
    // Phase D: run off the end of memory, drain, resume.
    add(0, 1, 32'd1012, 0, 0, 0,        32'd1012, 0);
    add(0, 0, 0,        0, 1, 32'd1012, 32'd1016, 0);
    add(0, 0, 0,        0, 1, 32'd1012, 32'd1020, 0);
    add(0, 0, 0,        0, 1, 32'd1012, 32'd1024, 1);
    add(0, 0, 0,        0, 1, 32'd1012, 32'd1024, 1);
    add(0, 0, 0,        1, 1, 32'd1016, 32'd1024, 1);
    add(0, 0, 0,        1, 1, 32'd1020, 32'd1024, 1);
    add(0, 0, 0,        1, 0, 0,        32'd1024, 1);
    add(0, 0, 0,        1, 0, 0,        32'd1024, 1);
    add(0, 1, 0,        1, 0, 0,        0,        0);
    add(0, 0, 0,        1, 1, 0,        32'd4,    0);
    add(0, 1, 32'hFFFF_FFFF, 1, 0, 0,   32'hFFFF_FFFC, 1);
    add(0, 0, 0,        1, 0, 0,        32'hFFFF_FFFC, 1);
    add(0, 1, 32'd1021, 0, 0, 0,        32'd1020, 0);
    add(0, 0, 0,        0, 1, 32'd1020, 32'd1024, 1);

    // Reset state, before any edge.
    #3;
    chk_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset          = vecs[i].rst;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      deq_ready      = vecs[i].rdy;
      @(posedge clk);
      #1;
      chk_all($sformatf("row%0d", i), vecs[i].ev, vecs[i].epc,
              vecs[i].ev ? (vecs[i].epc ^ instr_key) : 32'h0,
              vecs[i].eaddr, vecs[i].eoor);
    end

    // Asynchronous reset mid-cycle with a full queue.
    @(negedge clk);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    deq_ready      = 1'b0;
    instr_key      = 32'hDEAD_0000;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_all("full", 1'b1, 32'h0, 32'hDEAD_0000, 32'd16, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_all("first_enq", 1'b1, 32'h0, 32'hDEAD_0000, 32'd4, 1'b0);
    @(negedge clk);
    deq_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_all("second_enq", 1'b1, 32'd4, 32'hDEAD_0004, 32'd8, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
